// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic inter-stage pipeline register (D2X, X2M, M2W, ...). It carries a
//   payload bus and a control bus and uses a valid/ready handshake so that
//   downstream stalls apply back-pressure. A synchronous flush squashes
//   everything held or arriving. With SKID=1 a second (skid) entry lets
//   in_ready come straight from a flop, which breaks the combinational
//   ready path between neighbouring stages. The control bits are forced to
//   zero whenever the stage presents a bubble. This keeps stray memWrt or
//   regWrt bits from leaking downstream.
//
// Parameters:
//   DATA_W    payload width
//   CTRL_W    control width (gated to zero when out_valid=0)
//   SKID      1: main + skid entry, registered in_ready; 0: main entry only
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   upstream beat valid
//   in_ready   out  stage accepts a beat this cycle
//   in_data    in   upstream payload
//   in_ctrl    in   upstream control bits
//   flush      in   synchronous squash of held and incoming beats
//   out_valid  out  downstream beat valid
//   out_ready  in   downstream accepts the beat this cycle
//   out_data   out  payload of the oldest held beat
//   out_ctrl   out  control of the oldest beat, zero when out_valid=0
//   occupancy  out  number of beats currently held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic [CTRL_W-1:0] r_mainCtrl;

    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0] r_skidCtrl;

    logic              w_fireIn;
    logic              w_fireOut;

    assign w_fireIn  = in_valid & in_ready & ~flush;
    assign w_fireOut = r_mainValid & out_ready;

    // Main entry. It only reloads when it is empty or its beat leaves this
    // cycle, so out_data/out_ctrl hold steady during a stall. A waiting skid
    // beat is always older than the incoming beat and therefore goes first.
    // The skid entry can only be occupied while main is full, so the skid
    // branch is reached only on a fire_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_mainCtrl  <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
        end else if (!r_mainValid || w_fireOut) begin
            if (r_skidValid) begin
                r_mainValid <= 1'b1;
                r_mainData  <= r_skidData;
                r_mainCtrl  <= r_skidCtrl;
            end else if (w_fireIn) begin
                r_mainValid <= 1'b1;
                r_mainData  <= in_data;
                r_mainCtrl  <= in_ctrl;
            end else begin
                r_mainValid <= 1'b0;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Skid entry. It catches a beat that arrived while main was
            // stalled, and it drains into main on the next fire_out. While it
            // is full, in_ready is low, so no new beat can arrive at the same
            // time as the drain.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_skidValid <= 1'b0;
                    r_skidData  <= '0;
                    r_skidCtrl  <= '0;
                end else if (flush) begin
                    r_skidValid <= 1'b0;
                end else if (r_skidValid) begin
                    if (w_fireOut) begin
                        r_skidValid <= 1'b0;
                    end
                end else if (r_mainValid && !w_fireOut && w_fireIn) begin
                    r_skidValid <= 1'b1;
                    r_skidData  <= in_data;
                    r_skidCtrl  <= in_ctrl;
                end
            end

            // Ready is a pure flop output: there is room unless the skid entry is busy.
            assign in_ready = ~r_skidValid;
        end else begin : g_noSkid
            assign r_skidValid = 1'b0;
            assign r_skidData  = '0;
            assign r_skidCtrl  = '0;

            // Without a skid entry, a beat can only enter when main is empty
            // or is being emptied in this same cycle.
            assign in_ready = ~r_mainValid | out_ready;
        end
    endgenerate

    assign out_valid = r_mainValid;
    assign out_data  = r_mainData;
    assign out_ctrl  = r_mainValid ? r_mainCtrl : '0;
    assign occupancy = {1'b0, r_mainValid} + {1'b0, r_skidValid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Self-checking bench for pipe_stage_reg. One instance is built with
//   SKID=1 and one with SKID=0. Both instances share the stimulus wires.
//   selSkid picks which instance's outputs are observed. The reference
//   model is a bounded FIFO queue of beats. Its capacity is 2 with a skid
//   entry and 1 without.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic [DW-1:0] inData;
    logic [CW-1:0] inCtrl;
    logic          flush;
    logic          outReady;

    logic          ready1, valid1, ready0, valid0;
    logic [DW-1:0] data1, data0;
    logic [CW-1:0] ctrl1, ctrl0;
    logic [1:0]    occ1, occ0;

    bit            selSkid;
    logic          obsReady, obsValid;
    logic [DW-1:0] obsData;
    logic [CW-1:0] obsCtrl;
    logic [1:0]    obsOcc;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dutSkid (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ready1),
        .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
        .out_valid(valid1), .out_ready(outReady), .out_data(data1),
        .out_ctrl(ctrl1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dutNoSkid (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(ready0),
        .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
        .out_valid(valid0), .out_ready(outReady), .out_data(data0),
        .out_ctrl(ctrl0), .occupancy(occ0)
    );

    assign obsReady = selSkid ? ready1 : ready0;
    assign obsValid = selSkid ? valid1 : valid0;
    assign obsData  = selSkid ? data1  : data0;
    assign obsCtrl  = selSkid ? ctrl1  : ctrl0;
    assign obsOcc   = selSkid ? occ1   : occ0;

    // Model of readiness. With a skid entry the stage is ready while it
    // holds fewer than two beats. Without one, it is ready when empty or
    // when the held beat leaves this cycle.
    function automatic bit mReady();
        if (selSkid) return q.size() < 2;
        return (q.size() == 0) || (outReady == 1'b1);
    endfunction

    function automatic logic [CW-1:0] expCtrl();
        return (q.size() > 0) ? q[0].c : '0;
    endfunction

    function automatic logic [DW-1:0] expData();
        return (q.size() > 0) ? q[0].d : '0;
    endfunction

    // Advance one clock and update the queue model. This task performs no comparisons.
    task automatic tick();
        bit    fi, fo;
        beat_t b;
        fi = inValid && mReady() && !flush;
        fo = (q.size() > 0) && outReady;
        b.d = inData;
        b.c = inCtrl;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (fo) void'(q.pop_front());
            if (fi) q.push_back(b);
        end
        #1;
    endtask

    task automatic idleInputs();
        inValid  = 1'b0;
        inData   = '0;
        inCtrl   = '0;
        flush    = 1'b0;
        outReady = 1'b0;
    endtask

    // Reset pulse that spans one rising edge. It ends 1 time unit after a rising edge.
    task automatic applyReset();
        idleInputs();
        @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] a, b;
        selSkid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", obsValid); end
        checks++; if (obsCtrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl got %h exp 0", obsCtrl); end
        checks++; if (obsData !== '0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", obsData); end
        checks++; if (obsOcc !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d exp 0", obsOcc); end
        rst = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = a;
        inCtrl   = 8'h3C;
        tick();
        inData = b;
        tick();
        checks++; if (obsOcc !== 2'd2) begin errors++; $display("[TB] FAIL reset_fill_occ got %0d exp 2", obsOcc); end
        // Assert reset mid-cycle while a beat is still being offered.
        inData = ~a;
        #3;
        rst = 1'b0;
        q.delete();
        #1;
        checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_async_valid got %b exp 0", obsValid); end
        checks++; if (obsCtrl !== '0) begin errors++; $display("[TB] FAIL reset_async_ctrl got %h exp 0", obsCtrl); end
        checks++; if (obsOcc !== 2'd0) begin errors++; $display("[TB] FAIL reset_async_occ got %0d exp 0", obsOcc); end
        // Hold reset across a clock edge while a beat is still offered; nothing may be captured.
        @(posedge clk);
        #1;
        checks++; if (obsOcc !== 2'd0) begin errors++; $display("[TB] FAIL reset_hold_occ got %0d exp 0", obsOcc); end
        inValid = 1'b0;
        rst     = 1'b1;
        #2;
        checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready got %b exp 1", obsReady); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming(input bit skid);
        int            validCycles;
        logic [DW-1:0] e;
        selSkid = skid;
        applyReset();
        validCycles = 0;
        outReady = 1'b1;
        for (int i = 0; i < 11; i++) begin
            inValid = (i < 8);
            inData  = 64'h11 + 64'(i);
            inCtrl  = CW'($urandom);
            #2;
            checks++; if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready skid=%0d cyc %0d got %b exp 1", skid, i, obsReady); end
            tick();
            e = 64'h11 + 64'(i);
            if (obsValid === 1'b1) validCycles++;
            checks++; if (obsValid !== (i < 8)) begin errors++; $display("[TB] FAIL stream_valid skid=%0d cyc %0d got %b exp %b", skid, i, obsValid, (i < 8)); end
            checks++; if (obsOcc !== ((i < 8) ? 2'd1 : 2'd0)) begin errors++; $display("[TB] FAIL stream_occ skid=%0d cyc %0d got %0d", skid, i, obsOcc); end
            if (i < 8) begin
                checks++; if (obsData !== e) begin errors++; $display("[TB] FAIL stream_data skid=%0d cyc %0d got %h exp %h", skid, i, obsData, e); end
            end
        end
        checks++; if (validCycles != 8) begin errors++; $display("[TB] FAIL stream_count skid=%0d got %0d exp 8", skid, validCycles); end
    endtask

    task automatic test_stall(input bit skid);
        logic [DW-1:0] beats[3];
        logic [DW-1:0] got[$];
        int            idx;
        bit            acc;
        selSkid = skid;
        applyReset();
        for (int k = 0; k < 3; k++) beats[k] = {$urandom, $urandom};
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            outReady = (c >= 4);
            inValid  = (idx < 3);
            inData   = beats[idx < 3 ? idx : 2];
            inCtrl   = 8'h81;
            #2;
            if (skid && c == 2) begin
                checks++; if (obsReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_c3 got %b exp 0", obsReady); end
            end
            checks++; if (obsReady !== mReady()) begin errors++; $display("[TB] FAIL stall_ready skid=%0d cyc %0d got %b exp %b", skid, c, obsReady, mReady()); end
            checks++; if (obsOcc > (skid ? 2'd2 : 2'd1)) begin errors++; $display("[TB] FAIL stall_occ_bound skid=%0d got %0d", skid, obsOcc); end
            if (obsValid === 1'b1 && outReady) got.push_back(obsData);
            acc = inValid && mReady();
            tick();
            if (acc) idx++;
        end
        checks++; if (got.size() != 3) begin errors++; $display("[TB] FAIL stall_count skid=%0d got %0d exp 3", skid, got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            checks++; if (got[k] !== beats[k]) begin errors++; $display("[TB] FAIL stall_order skid=%0d idx %0d got %h exp %h", skid, k, got[k], beats[k]); end
        end
    endtask

    task automatic test_flush();
        selSkid = 1'b1;
        applyReset();
        outReady = 1'b0;
        inValid  = 1'b1;
        inCtrl   = 8'h5A;
        inData   = 64'hAAAA;
        tick();
        inData = 64'hBBBB;
        tick();
        checks++; if (obsOcc !== 2'd2) begin errors++; $display("[TB] FAIL flush_fill_occ got %0d exp 2", obsOcc); end
        flush  = 1'b1;
        inData = 64'hDDDD;
        inCtrl = 8'hFF;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid cyc %0d got %b exp 0", c, obsValid); end
            checks++; if (obsCtrl !== '0) begin errors++; $display("[TB] FAIL flush_ctrl cyc %0d got %h exp 0", c, obsCtrl); end
            checks++; if (obsOcc !== 2'd0) begin errors++; $display("[TB] FAIL flush_occ cyc %0d got %0d exp 0", c, obsOcc); end
            tick();
        end
        // Flush while the stage still has room: the offered beat must be dropped.
        inValid = 1'b1;
        inData  = 64'h1234;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        checks++; if (obsValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_valid got %b exp 0", obsValid); end
    endtask

    task automatic test_ctrl_gating();
        int seen;
        selSkid = 1'b1;
        applyReset();
        outReady = 1'b1;
        inValid  = 1'b0;
        inCtrl   = 8'hFF;
        tick();
        checks++; if (obsCtrl !== '0) begin errors++; $display("[TB] FAIL gate_bubble_ctrl got %h exp 00", obsCtrl); end
        inValid = 1'b1;
        inCtrl  = 8'hA5;
        inData  = {$urandom, $urandom};
        tick();
        inValid = 1'b0;
        inCtrl  = 8'hFF;
        checks++; if (obsCtrl !== 8'hA5) begin errors++; $display("[TB] FAIL gate_beat_ctrl got %h exp a5", obsCtrl); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (obsCtrl !== '0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL gate_after_ctrl got %0d nonzero cycles exp 0", seen); end
    endtask

    task automatic test_random(input bit skid);
        bit pending;
        bit acc;
        selSkid = skid;
        applyReset();
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                inValid = ($urandom_range(3) != 0);
                inData  = {$urandom, $urandom};
                inCtrl  = CW'($urandom);
            end
            outReady = ($urandom_range(2) != 0);
            flush    = ($urandom_range(15) == 0);
            #2;
            checks++; if (obsReady !== mReady()) begin errors++; $display("[TB] FAIL rand_ready skid=%0d cyc %0d got %b exp %b", skid, c, obsReady, mReady()); end
            acc     = inValid && mReady() && !flush;
            pending = inValid && !acc && !flush;
            tick();
            checks++; if (obsValid !== (q.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid skid=%0d cyc %0d got %b exp %b", skid, c, obsValid, (q.size() > 0)); end
            checks++; if (obsCtrl !== expCtrl()) begin errors++; $display("[TB] FAIL rand_ctrl skid=%0d cyc %0d got %h exp %h", skid, c, obsCtrl, expCtrl()); end
            checks++; if (obsOcc !== 2'(q.size())) begin errors++; $display("[TB] FAIL rand_occ skid=%0d cyc %0d got %0d exp %0d", skid, c, obsOcc, q.size()); end
            if (q.size() > 0) begin
                checks++; if (obsData !== expData()) begin errors++; $display("[TB] FAIL rand_data skid=%0d cyc %0d got %h exp %h", skid, c, obsData, expData()); end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        selSkid = 1'b1;
        idleInputs();
        test_reset();
        test_streaming(1'b1);
        test_stall(1'b1);
        test_flush();
        test_ctrl_gating();
        test_random(1'b1);
        test_streaming(1'b0);
        test_stall(1'b0);
        test_random(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
